// File: rtl/jedec_rd_pkg.sv
// Shared types and constants for the JEDEC read responder model.
// Read command opcode, FSM state encoding, pending-entry layout and the LFSR step.
package jedec_rd_pkg;

  localparam logic [4:0] READ_OP = 5'b11101;
  localparam int         CNT_W   = 6;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    BURST
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] countdown;
    logic             valid;
  } entry_t;

  // Fibonacci x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/jedec_rd_queue.sv
// Pending-read FIFO: each entry counts down toward its burst start and parks at zero.
// Head sits at index 0; a pop shifts the whole queue down by one.
module jedec_rd_queue
  import jedec_rd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RL    = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             head_due,
  output logic [CNT_W-1:0] head_cnt
);

  localparam int CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  entry_t        nxt [DEPTH];
  logic [CW-1:0] count;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) nxt[i] = mem[i];
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) nxt[i] = mem[i + 1];
      nxt[DEPTH-1] = '0;
    end
    for (int i = 0; i < DEPTH; i++)
      if (nxt[i].valid && nxt[i].countdown != '0)
        nxt[i].countdown = nxt[i].countdown - 1'b1;
    // Pop precedes push, so a full queue still accepts on a pop edge.
    for (int i = 0; i < DEPTH; i++)
      if (push && i == int'(count) - int'(pop))
        nxt[i] = '{countdown: CNT_W'(RL - 1), valid: 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= nxt[i];
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign head_due = mem[0].valid && (mem[0].countdown == '0);
  assign head_cnt = mem[0].countdown;

endmodule

// File: rtl/jedec_rd_responder.sv
// DRAM-side read responder: turns READ commands into DQS/DQ bursts after RL cycles.
// Define JEDEC_RD_LFSR_EN to replace the incrementing data pattern with an 8-bit LFSR.
module jedec_rd_responder
  import jedec_rd_pkg::*;
#(
  parameter int DEVICE_WIDTH = 4,
  parameter int RL           = 22,
  parameter int BL           = 16,
  parameter int PRE_CYCLES   = 2,
  parameter int DEPTH        = 4
) (
  input  logic                      dfi_phy_clk,
  input  logic                      rst_n,
  input  logic [13:0]               CA_DA_o,
  input  logic                      CS_DA_o,
  input  logic                      CA_VALID_DA_o,
  output logic                      DQS_AD_i,
  output logic [2*DEVICE_WIDTH-1:0] DQ_AD_i,
  output logic                      err_overflow,
  output logic                      err_collision
);

  localparam int               BEATS   = BL / 2;
  localparam logic [2:0]       LAST    = 3'(BEATS - 1);
  localparam logic [CNT_W-1:0] PRE_CNT = CNT_W'(PRE_CYCLES);
`ifdef JEDEC_RD_LFSR_EN
  localparam logic [7:0]       PAT_SEED = 8'h01;
`else
  localparam logic [7:0]       PAT_SEED = 8'h00;
`endif

  state_t           state, next_state;
  logic [2:0]       burst_cnt;
  logic             skip, read_det, push, pop, drop, start, defer;
  logic             full, empty, head_due;
  logic [CNT_W-1:0] head_cnt;
  logic [7:0]       pat, lo_pat, hi_pat, pat_next;
  logic             ca_unused;

  function automatic logic [DEVICE_WIDTH-1:0] fit(input logic [7:0] p);
    return DEVICE_WIDTH'(p);
  endfunction

  assign ca_unused = ^CA_DA_o[13:5];

  // skip masks the second command UI and the first edge out of reset.
  assign read_det = !skip && !CS_DA_o && CA_VALID_DA_o && (CA_DA_o[4:0] == READ_OP);
  assign pop      = start;
  assign push     = read_det && (!full || pop);
  assign drop     = read_det && full && !pop;

  jedec_rd_queue #(.DEPTH(DEPTH), .RL(RL)) u_queue (
    .clk      (dfi_phy_clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head_due (head_due),
    .head_cnt (head_cnt)
  );

  always_ff @(posedge dfi_phy_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state <= next_state;
      if (start)                                    burst_cnt <= '0;
      else if (state == BURST && next_state == BURST) burst_cnt <= burst_cnt + 3'd1;
    end
  end

  always_comb begin
    next_state = IDLE;
    start      = 1'b0;
    defer      = 1'b0;
    case (state)
      BURST: begin
        if (burst_cnt != LAST) begin
          next_state = BURST;
          defer      = head_due;
        end else if (head_due) begin
          next_state = BURST;
          start      = 1'b1;
        end else if (!empty && head_cnt <= PRE_CNT) begin
          next_state = PRE;
        end
      end
      default: begin
        if (head_due) begin
          next_state = BURST;
          start      = 1'b1;
        end else if (!empty && head_cnt <= PRE_CNT) begin
          next_state = PRE;
        end
      end
    endcase
  end

  always_comb begin
`ifdef JEDEC_RD_LFSR_EN
    lo_pat   = lfsr_step(pat);
    hi_pat   = lfsr_step(lo_pat);
    pat_next = hi_pat;
`else
    lo_pat   = pat;
    hi_pat   = pat + 8'd1;
    pat_next = pat + 8'd2;
`endif
  end

  // Output stage: registered strobe/data for the cycle that begins at this edge.
  always_ff @(posedge dfi_phy_clk or negedge rst_n) begin
    if (!rst_n) begin
      skip          <= 1'b1;
      DQS_AD_i      <= 1'b0;
      DQ_AD_i       <= '0;
      pat           <= PAT_SEED;
      err_overflow  <= 1'b0;
      err_collision <= 1'b0;
    end else begin
      skip <= read_det;
      if (drop)  err_overflow  <= 1'b1;
      if (defer) err_collision <= 1'b1;
      if (next_state == BURST) begin
        DQS_AD_i <= start ? 1'b1 : ~DQS_AD_i;
        DQ_AD_i  <= {fit(hi_pat), fit(lo_pat)};
        pat      <= pat_next;
      end else begin
        DQS_AD_i <= 1'b0;
        DQ_AD_i  <= '0;
      end
    end
  end

endmodule
